fifo_rd_packer: RTL and testbench
=================================

// Module: fifo_rd_packer
// PURPOSE
//  Read-side consumer of async_fifo; lives entirely in the read clock domain.
//  Drains bytes from the FIFO read port and packs PACK bytes into one word.
//  Presents each word on a valid/ready stream to the downstream datapath.
//  Never reads an empty FIFO, so the FIFO's rd_error_o must stay 0.
// PARAMETERS
//  WIDTH    8   FIFO data width (bits per byte lane)
//  PACK     4   lanes per output word (2..8)
//  TMO_CYC  16  idle cycles before auto-flush (used only with the optional macro)
// PORTS
//  rd_clk_i      in   1           clock (FIFO read clock)
//  rst_i         in   1           asynchronous, active-high reset
//  empty_i       in   1           FIFO empty_o
//  rd_en_o       out  1           FIFO rd_en_i
//  rdata_i       in   WIDTH       FIFO rdata_o; valid the cycle after rd_en_o=1
//  out_valid_o   out  1           output word valid
//  out_ready_i   in   1           downstream accepts the word
//  out_data_o    out  PACK*WIDTH  packed word; first byte read in lane 0 [WIDTH-1:0]
//  out_keep_o    out  PACK        lane-valid mask; all ones except on partial words
//  flush_i       in   1           one-cycle pulse: emit the partial word
//  flush_done_o  out  1           one-cycle pulse when a flush completes
//  word_cnt_o    out  16          words accepted downstream; wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset (asynchronous): all outputs are 0; state=FILL; cnt=0; rd_pend=0.
//  Internal state:
//   - cnt: lanes filled in the accumulator.
//   - rd_pend: a read was issued last cycle.
//   - 1-entry output register.
//  Read issue (combinational):
//   - rd_en_o = !empty_i && state==FILL && (cnt+rd_pend < PACK).
//   - A read is never issued while empty_i=1.
//  Data capture: when rd_pend=1, rdata_i goes into lane cnt and cnt increments.
//  Word completion:
//   - When cnt==PACK, the accumulator moves to the output register if
//     out_valid_o=0 or out_ready_i=1 in that cycle. Then cnt=0 and keep=all ones.
//   - Otherwise state=HOLD: reads stop and the accumulator is held.
//   - HOLD->FILL on the cycle the transfer happens.
//  Output stream:
//   - out_valid_o stays 1 and out_data_o/out_keep_o stay stable until out_ready_i=1.
//   - Transfer into the output register happens in the same cycle as acceptance,
//     so there is no bubble.
//   - word_cnt_o increments on each valid&&ready.
//  Latency: the first byte enters lane 0 one cycle after its rd_en_o.
//   Peak rate: PACK bytes per PACK+1 cycles (one bubble per word).
//  FLUSH:
//   - A flush_i pulse in FILL or HOLD sets state=FLUSH; reads stop.
//   - Wait for any rd_pend byte to land, then emit the accumulator with
//     keep = (1<<cnt)-1. Unused lanes are 0.
//   - flush_done_o pulses on the cycle that word is accepted downstream.
//   - If cnt==0 and rd_pend=0: no word is emitted; flush_done_o pulses the next cycle.
//   - Then state=FILL.
//   - flush_i while already in FLUSH is ignored.
//  Simultaneous events: flush_i on the cycle the last lane lands emits a full
//   word (keep all ones), then flush_done_o follows per the rules above.
//  Reset mid-word: the accumulator contents are lost.
//   The FIFO shares rst_i, so stream state stays consistent.
// CONFIGURATION
//  FIFO_RD_PACKER_TIMEOUT_EN defined:
//   - An idle counter counts cycles in FILL with cnt>0 and rd_en_o=0.
//   - It clears on any read.
//   - On reaching TMO_CYC it triggers an internal flush, identical to flush_i,
//     but flush_done_o stays 0.
//  Not defined: no counter logic; partial words wait for flush_i; TMO_CYC unused.
// TESTING
//  1. Reset: rst_i=1 -> rd_en_o=0, out_valid_o=0, word_cnt_o=0, even when empty_i=0.
//  2. FIFO holds 8 bytes 01..08, out_ready_i=1 -> words 32'h04030201 then
//     32'h08070605, keep=4'hF, word_cnt_o=2, no read while empty_i=1.
//  3. Backpressure: out_ready_i=0 with 12 bytes queued -> one word held stable,
//     a second word in HOLD, rd_en_o=0 after 8 reads; release -> 3 words in order.
//  4. 3 bytes AA,BB,CC then flush_i -> 32'h00CCBBAA, keep=4'h7, flush_done_o on accept.
//  5. flush_i with an empty accumulator -> no out_valid_o; flush_done_o one cycle later.
//  6. Macro on, TMO_CYC=16, 2 bytes then empty_i=1 -> after 16 idle cycles, keep=4'h3.
//     Macro off, same stimulus -> no output.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Drains bytes from an async_fifo read port and packs PACK lanes per word onto a valid/ready stream.
// Lane 0 fills one cycle after its rd_en_o; output stalls hold the full accumulator; FIFO_RD_PACKER_TIMEOUT_EN enables idle auto-flush.
module fifo_rd_packer #(
    parameter int WIDTH   = 8,
    parameter int PACK    = 4,
    parameter int TMO_CYC = 16
) (
    input  logic                    rd_clk_i,
    input  logic                    rst_i,
    input  logic                    empty_i,
    output logic                    rd_en_o,
    input  logic [WIDTH-1:0]        rdata_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [PACK*WIDTH-1:0]   out_data_o,
    output logic [PACK-1:0]         out_keep_o,
    input  logic                    flush_i,
    output logic                    flush_done_o,
    output logic [15:0]             word_cnt_o
);
    localparam int CW = $clog2(PACK + 1);
    localparam logic [CW-1:0] PACK_C = CW'(PACK);

    typedef enum logic [1:0] {FILL, HOLD, FLUSH, FLUSH_WAIT} state_t;

    state_t                         state, state_nx;
    logic [CW-1:0]                  cnt, cnt_n, cnt_sum;
    logic                           rd_pend;
    logic [PACK-1:0][WIDTH-1:0]     acc, acc_cap;
    logic [PACK-1:0]                part_keep, keep_n;
    logic                           load, slot_free, flush_req, tmo_hit;
    logic                           quiet, quiet_n, done;

    assign cnt_sum   = cnt + CW'(rd_pend);
    assign slot_free = !out_valid_o || out_ready_i;
    assign flush_req = flush_i || tmo_hit;

    // Gated by rst_i so no read is requested while the FIFO is held in reset.
    assign rd_en_o      = !rst_i && !empty_i && (state == FILL) && (cnt_sum < PACK_C);
    assign flush_done_o = done;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] idle_cnt;
    logic          idle;

    assign idle    = (state == FILL) && (cnt != '0) && !rd_en_o;
    assign tmo_hit = idle && (idle_cnt == TW'(TMO_CYC - 1));

    always_ff @(posedge rd_clk_i or posedge rst_i) begin
        if (rst_i) begin
            idle_cnt <= '0;
        end else if (!idle) begin
            idle_cnt <= '0;
        end else if (!tmo_hit) begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        acc_cap   = acc;
        part_keep = '0;
        for (int i = 0; i < PACK; i++) begin
            if (rd_pend && (cnt == CW'(i))) begin
                acc_cap[i] = rdata_i;
            end
            part_keep[i] = (CW'(i) < cnt);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_n    = cnt_sum;
        load     = 1'b0;
        keep_n   = '1;
        quiet_n  = quiet;
        done     = 1'b0;
        case (state)
            FILL, HOLD: begin
                if (cnt_sum == PACK_C) begin
                    if (slot_free) begin
                        load     = 1'b1;
                        cnt_n    = '0;
                        state_nx = FILL;
                    end else begin
                        state_nx = HOLD;
                    end
                end
                // A timeout-triggered flush completes silently.
                if (flush_req) begin
                    state_nx = FLUSH;
                    quiet_n  = !flush_i;
                end
            end
            FLUSH: begin
                if (!rd_pend) begin
                    if (cnt == '0) begin
                        done     = !quiet;
                        state_nx = FILL;
                    end else if (slot_free) begin
                        load     = 1'b1;
                        keep_n   = part_keep;
                        cnt_n    = '0;
                        state_nx = FLUSH_WAIT;
                    end
                end
            end
            FLUSH_WAIT: begin
                if (out_valid_o && out_ready_i) begin
                    done     = !quiet;
                    state_nx = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge rd_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= FILL;
            cnt         <= '0;
            rd_pend     <= 1'b0;
            acc         <= '0;
            quiet       <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_keep_o  <= '0;
            word_cnt_o  <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_n;
            rd_pend <= rd_en_o;
            quiet   <= quiet_n;
            acc     <= load ? '0 : acc_cap;
            if (load) begin
                out_valid_o <= 1'b1;
                out_data_o  <= acc_cap;
                out_keep_o  <= keep_n;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
            word_cnt_o <= word_cnt_o + 16'(out_valid_o && out_ready_i);
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: queue-based FIFO model, directed scenarios, then random traffic
// checked for byte order/conservation, keep shape, hold stability and flush completion.
module tb_fifo_rd_packer;
    localparam int WIDTH = 8;
    localparam int PACK  = 4;

    logic        clk = 1'b0;
    logic        rst_i, empty_i, rd_en_o, out_valid_o, out_ready_i, flush_i, flush_done_o;
    logic [7:0]  rdata_i;
    logic [31:0] out_data_o;
    logic [3:0]  out_keep_o;
    logic [15:0] word_cnt_o;

    always #5 clk = ~clk;

    fifo_rd_packer #(.WIDTH(WIDTH), .PACK(PACK), .TMO_CYC(16)) dut (
        .rd_clk_i(clk), .rst_i(rst_i), .empty_i(empty_i), .rd_en_o(rd_en_o),
        .rdata_i(rdata_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_keep_o(out_keep_o), .flush_i(flush_i),
        .flush_done_o(flush_done_o), .word_cnt_o(word_cnt_o)
    );

    int          n_tests = 0, n_fail = 0;
    int          n_hs = 0, n_done = 0, n_done_hs = 0, n_partial = 0;
    byte unsigned fifo_q[$], popped[$], out_bytes[$];
    logic [35:0] got_words[$], exp_words[$];
    logic        prev_hold, last_done, last_valid;
    logic [35:0] prev_word;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at negedge, observe, then present read data after the edge.
    task automatic cyc(input logic rdy, input logic fl);
        byte unsigned nb;
        @(negedge clk);
        out_ready_i = rdy;
        flush_i     = fl;
        empty_i     = (fifo_q.size() == 0);
        #1;
        nb = 8'($urandom);
        check("no_read_when_empty", {63'd0, rd_en_o & empty_i}, 64'd0);
        if (prev_hold) begin
            check("hold_valid", {63'd0, out_valid_o}, 64'd1);
            check("hold_word", {28'd0, out_keep_o, out_data_o}, {28'd0, prev_word});
        end
        if (rd_en_o && fifo_q.size() > 0) begin
            nb = fifo_q.pop_front();
            popped.push_back(nb);
        end
        if (out_valid_o && out_ready_i) begin
            n_hs++;
            got_words.push_back({out_keep_o, out_data_o});
            for (int l = 0; l < PACK; l++)
                if (out_keep_o[l]) out_bytes.push_back(out_data_o[8*l +: 8]);
            if (out_keep_o != 4'hF) n_partial++;
        end
        if (flush_done_o) begin
            n_done++;
            if (out_valid_o && out_ready_i) n_done_hs++;
        end
        last_done  = flush_done_o;
        last_valid = out_valid_o;
        prev_hold  = out_valid_o && !out_ready_i;
        prev_word  = {out_keep_o, out_data_o};
        @(posedge clk);
        #1;
        rdata_i = nb;
    endtask

    task automatic run(input int n, input logic rdy);
        repeat (n) cyc(rdy, 1'b0);
    endtask

    task automatic clear();
        got_words.delete(); exp_words.delete(); popped.delete(); out_bytes.delete();
        n_done = 0; n_done_hs = 0; n_partial = 0;
    endtask

    // Expected full words straight from a byte list: byte k goes to lane k%PACK.
    task automatic push_bytes_expect(input byte unsigned b[$]);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < b.size(); i++) begin
            fifo_q.push_back(b[i]);
            w[8*(i%PACK) +: 8] = b[i];
            if (i % PACK == PACK - 1) begin
                exp_words.push_back({4'hF, w});
                w = '0;
            end
        end
    endtask

    task automatic cmp_words(input string tag);
        check({tag, "_count"}, 64'(got_words.size()), 64'(exp_words.size()));
        for (int i = 0; i < exp_words.size() && i < got_words.size(); i++)
            check(tag, {28'd0, got_words[i]}, {28'd0, exp_words[i]});
    endtask

    task automatic shape_checks();
        logic [3:0]  k;
        logic [31:0] d, m;
        for (int i = 0; i < got_words.size(); i++) begin
            k = got_words[i][35:32];
            d = got_words[i][31:0];
            m = '0;
            for (int l = 0; l < PACK; l++) if (k[l]) m[8*l +: 8] = 8'hFF;
            check("keep_shape", {63'd0, (k != 4'h0) && ((k & (k + 4'd1)) == 4'h0)}, 64'd1);
            check("pad_zero", {32'd0, d & ~m}, 64'd0);
        end
    endtask

    initial begin
        byte unsigned bl[$];
        int nfl, age;
        logic outstanding, rdy, fl;

        // Reset with FIFO reporting data available
        rst_i = 1'b1; empty_i = 1'b0; out_ready_i = 1'b1; flush_i = 1'b0; rdata_i = '0;
        prev_hold = 1'b0; prev_word = '0; last_done = 1'b0; last_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", {63'd0, rd_en_o}, 64'd0);
        check("rst_valid", {63'd0, out_valid_o}, 64'd0);
        check("rst_word_cnt", {48'd0, word_cnt_o}, 64'd0);
        check("rst_flush_done", {63'd0, flush_done_o}, 64'd0);
        check("rst_keep", {60'd0, out_keep_o}, 64'd0);
        empty_i = 1'b1;
        rst_i   = 1'b0;

        // Eight bytes, free-flowing output
        clear();
        bl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        push_bytes_expect(bl);
        run(20, 1'b1);
        cmp_words("basic");
        check("basic_word_cnt", {48'd0, word_cnt_o}, 64'(16'(n_hs)));

        // Backpressure: one word in the output register, one held, reads stop
        clear();
        bl.delete();
        for (int i = 0; i < 12; i++) bl.push_back(8'(8'h11 + i));
        push_bytes_expect(bl);
        run(20, 1'b0);
        check("bp_reads", 64'(popped.size()), 64'd8);
        check("bp_valid", {63'd0, out_valid_o}, 64'd1);
        check("bp_no_accept", 64'(got_words.size()), 64'd0);
        run(20, 1'b1);
        cmp_words("bp_release");
        check("bp_word_cnt", {48'd0, word_cnt_o}, 64'(16'(n_hs)));

        // Partial word by flush
        clear();
        fifo_q.push_back(8'hAA); fifo_q.push_back(8'hBB); fifo_q.push_back(8'hCC);
        exp_words.push_back({4'h7, 32'h00CCBBAA});
        run(10, 1'b1);
        cyc(1'b1, 1'b1);
        run(10, 1'b1);
        cmp_words("flush_partial");
        check("flush_done_cnt", 64'(n_done), 64'd1);
        check("flush_done_on_accept", 64'(n_done_hs), 64'd1);

        // Flush with nothing accumulated
        clear();
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        check("empty_flush_done", {63'd0, last_done}, 64'd1);
        check("empty_flush_novalid", {63'd0, last_valid}, 64'd0);
        run(5, 1'b1);
        check("empty_flush_words", 64'(got_words.size()), 64'd0);
        check("empty_flush_done_cnt", 64'(n_done), 64'd1);

        // Two bytes then idle
        clear();
        fifo_q.push_back(8'h5A); fifo_q.push_back(8'hA5);
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        exp_words.push_back({4'h3, 32'h0000A55A});
`endif
        run(40, 1'b1);
        cmp_words("idle_timeout");
        check("idle_no_done", 64'(n_done), 64'd0);
        cyc(1'b1, 1'b1);
        run(10, 1'b1);

        // Random traffic
        clear();
        nfl = 0; age = 0; outstanding = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) < 4) fifo_q.push_back(8'($urandom));
            rdy = ($urandom_range(0, 9) < 7);
            fl  = 1'b0;
            if (!outstanding && $urandom_range(0, 49) == 0) begin
                fl = 1'b1; outstanding = 1'b1; nfl++; age = 0;
            end
            cyc(rdy, fl);
            age++;
            if (last_done) outstanding = 1'b0;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
            if (age > 64) outstanding = 1'b0;
`endif
        end
        run(40, 1'b1);
        cyc(1'b1, 1'b1);
        nfl++;
        run(10, 1'b1);
        check("drain_fifo_empty", 64'(fifo_q.size()), 64'd0);
        check("byte_count", 64'(out_bytes.size()), 64'(popped.size()));
        for (int i = 0; i < popped.size() && i < out_bytes.size(); i++) begin
            check("byte_order", 64'(out_bytes[i]), 64'(popped[i]));
            if (out_bytes[i] != popped[i]) break;
        end
        shape_checks();
`ifndef FIFO_RD_PACKER_TIMEOUT_EN
        check("rand_flush_done", 64'(n_done), 64'(nfl));
        check("rand_partial_le_flush", {63'd0, n_partial <= nfl}, 64'd1);
`endif
        check("rand_word_cnt", {48'd0, word_cnt_o}, 64'(16'(n_hs)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
